pwm_meter: RTL

PWM_METER -- requirements
Module: pwm_meter

---
 rtl/pwm_meter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pwm_meter.sv
// PWM period / high-time meter with stall detection on a free-running counter.
// Optional glitch filter enabled by defining PWM_METER_FILTER_EN.
module pwm_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high,
  output logic             valid,
  output logic             stalled,
  output logic             level
);

  typedef enum logic [1:0] {
    SYNC,
    HIGH,
    LOW
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_lat;
  logic             hi_load;
  logic             meas;
  logic             stall_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef PWM_METER_FILTER_EN
  // f only follows s2 once it has held for two samples
  logic f;
  logic stable;

  assign stable = (s2 == s3);
  assign rise   = stable & s2 & ~f;
  assign fall   = stable & ~s2 & f;
  assign level  = f;

  always_ff @(posedge clk) begin
    if (rst) begin
      f <= 1'b0;
    end else if (stable) begin
      f <= s2;
    end
  end
`else
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    hi_load   = 1'b0;
    meas      = 1'b0;
    stall_set = 1'b0;
    unique case (state)
      SYNC: begin
        if (rise) state_nxt = HIGH;
      end
      HIGH: begin
        if (fall) begin
          hi_load   = 1'b1;
          state_nxt = LOW;
        end else if (cnt == MAX) begin
          stall_set = 1'b1;
          state_nxt = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          meas      = 1'b1;
          state_nxt = HIGH;
        end else if (cnt == MAX) begin
          stall_set = 1'b1;
          state_nxt = SYNC;
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SYNC;
      hi_lat  <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      stalled <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= meas;
      if (hi_load) hi_lat <= cnt;
      if (meas) begin
        period <= cnt;
        high   <= hi_lat;
      end
      if (stall_set) begin
        stalled <= 1'b1;
      end else if (rise) begin
        stalled <= 1'b0;
      end
    end
  end

endmodule
